amo_lrsc_unit: RTL and testbench
================================

Name: amo_lrsc_unit

Overview:
- Per-core atomic execution unit in the LSU path; the client/initiator side of the LR/SC reservation set.
- Accepts decoded A-extension ops (LR, SC, AMO*) from the pipeline and sequences memory read/write transactions.
- Drives the reservation set's LR/SC ports and samples its SC verdict.
- Broadcasts store notifications so other harts' reservations are invalidated.

Parameters:
XLEN, 64, data/address width
NUM_HARTS, 4, number of harts sharing the reservation set
HART_W, $clog2(NUM_HARTS), hart id width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  op request
req_ready  out  1  unit idle, request accepted when valid&&ready
req_op  in  4  0 LR, 1 SC, 2 SWAP, 3 ADD, 4 XOR, 5 AND, 6 OR, 7 MIN, 8 MAX, 9 MINU, 10 MAXU; 11-15 illegal
req_is_word  in  1  1 = .W, 0 = .D
req_addr  in  XLEN  rs1
req_wdata  in  XLEN  rs2
req_hart_id  in  HART_W  issuing hart
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  rd value
resp_fault  out  1  misaligned address or illegal op
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 write, 0 read
mem_req_addr  out  XLEN  access address
mem_req_wdata  out  XLEN  write data (low 32 bits for word)
mem_req_is_word  out  1  access size
mem_resp_valid  in  1  read data / write ack
mem_resp_rdata  in  XLEN  read data
rs_hart_id  out  HART_W  hart for LR/SC
rs_lr_valid  out  1  create reservation
rs_lr_addr  out  XLEN  reservation address
rs_lr_is_word  out  1  reservation size
rs_sc_valid  out  1  SC query/consume
rs_sc_addr  out  XLEN  SC address
rs_sc_is_word  out  1  SC size
rs_sc_success  in  1  combinational verdict, valid while rs_sc_valid
rs_store_valid  out  1  store-notify pulse
rs_store_addr  out  XLEN  stored address
rs_store_hart_id  out  HART_W  storing hart

Behaviour:
- Reset: state IDLE; every output 0 except req_ready=1 once in IDLE. Reset mid-op aborts immediately. Any late mem_resp_valid is ignored in IDLE.
- req_ready = (state==IDLE). On accept, latch op, is_word, addr, wdata and hart_id. All rs_*/mem_* addresses, data and ids come from these latches.
- FSM states: IDLE, SC_CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- Fault check on accept:
  - Word ops need addr[1:0]==0; doubleword ops need addr[2:0]==0.
  - Ops 11-15 are illegal.
  - On fault: IDLE->RESP with resp_fault=1, resp_rdata=0. No memory or rs activity.
- LR: RD_REQ -> RD_WAIT.
  - On mem_resp_valid, pulse rs_lr_valid for one cycle and capture data, then go to RESP.
- SC:
  - SC_CHECK lasts exactly one cycle: rs_sc_valid=1, rs_sc_success is sampled.
  - Success -> WR_REQ. Failure -> RESP with rdata=1; no memory write, no store notify.
  - After the write ack, RESP with rdata=0.
- AMO: RD_REQ -> RD_WAIT.
  - On read data: old = data; new = f(old, wdata), registered; go to WR_REQ.
  - WR_REQ -> WR_WAIT. On ack, go to RESP with rdata=old.
- mem_req_valid is held in RD_REQ/WR_REQ until mem_req_ready. Addr, we, wdata and size stay stable while valid.
  - Handshake cycle -> *_WAIT.
  - mem_resp_valid arriving in a *_REQ state is illegal; the design does not need to handle it.
- rs_store_valid pulses in the cycle the write ack (mem_resp_valid in WR_WAIT) is seen, for SC-success and all AMOs.
- RESP lasts one cycle: resp_valid=1, then IDLE. req_ready=1 the following cycle.
- Word arithmetic:
  - Operate on bits [31:0]; MIN/MAX compare signed 32-bit, MINU/MAXU unsigned 32-bit.
  - ADD wraps mod 2^32 for word ops and mod 2^64 for doubleword ops.
  - The memory write uses the low 32 bits.
  - resp_rdata is sign-extended bit 31 for all word ops, including the LR value and the SC 0/1 result.
- Latency with zero-wait memory (ready=1, response next cycle), counted from accept edge to resp_valid:
  - Fault: 1 cycle.
  - LR: 3 cycles.
  - SC fail: 2 cycles.
  - SC success: 4 cycles.
  - AMO: 5 cycles.

Test Plan:
- LR.D 0x1000, mem returns 0xDEAD_BEEF_0000_0001 -> one rs_lr_valid pulse (addr 0x1000, is_word=0); resp_rdata=0xDEADBEEF00000001, fault=0, 3-cycle latency.
- SC.W 0x2000 with rs_sc_success=1, wdata=0x1234 -> one rs_sc_valid cycle; write 0x1234 to 0x2000 (word); rs_store_valid with addr 0x2000; resp_rdata=0. Same op with success=0 -> no mem write, no store notify, resp_rdata=1.
- AMOADD.W 0x3000, mem old 0x7FFF_FFFF, wdata 1 -> write 0x8000_0000; resp_rdata=0x0000_0000_7FFF_FFFF. AMOMIN.W old 0xFFFF_FFFF, wdata 5 -> write 0xFFFF_FFFF, resp_rdata=0xFFFF_FFFF_FFFF_FFFF. AMOMINU.W same inputs -> write 5.
- AMOSWAP.D 0x4004 (misaligned) -> resp_fault=1 one cycle after accept; mem_req_valid and every rs_* output stay 0. Op 12 -> same fault response.
- Memory backpressure: mem_req_ready low 3 cycles during the AMOOR.D write -> mem_req_valid, addr and wdata held stable; completion delayed exactly 3 cycles.
- Assert rst in RD_WAIT of an AMO, then deliver mem_resp_valid -> outputs 0, req_ready=1, no write issued, no resp_valid.

Source files
------------

// File: rtl/amo_lrsc_unit.sv
// Atomic execution unit: sequences LR/SC/AMO ops into memory read/write
// transactions and drives the shared LR/SC reservation set.
module amo_lrsc_unit #(
  parameter int XLEN      = 64,
  parameter int NUM_HARTS = 4,
  parameter int HART_W    = $clog2(NUM_HARTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic              req_is_word,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [HART_W-1:0] req_hart_id,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic              mem_req_is_word,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata,
  output logic [HART_W-1:0] rs_hart_id,
  output logic              rs_lr_valid,
  output logic [XLEN-1:0]   rs_lr_addr,
  output logic              rs_lr_is_word,
  output logic              rs_sc_valid,
  output logic [XLEN-1:0]   rs_sc_addr,
  output logic              rs_sc_is_word,
  input  logic              rs_sc_success,
  output logic              rs_store_valid,
  output logic [XLEN-1:0]   rs_store_addr,
  output logic [HART_W-1:0] rs_store_hart_id
);

  localparam logic [3:0] OP_LR   = 4'd0;
  localparam logic [3:0] OP_SC   = 4'd1;
  localparam logic [3:0] OP_SWAP = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_MIN  = 4'd7;
  localparam logic [3:0] OP_MAX  = 4'd8;
  localparam logic [3:0] OP_MINU = 4'd9;
  localparam logic [3:0] OP_MAXU = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_SC_CHECK, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic                is_word_q, is_word_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;   // write data: rs2 for SC, f(old, rs2) for AMO
  logic [HART_W-1:0]   hart_q, hart_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;   // rd value presented in RESP
  logic                fault_q, fault_d;

  logic                req_misaligned;
  logic                req_fault;
  logic [31:0]         a_w, b_w, r_w;
  logic [XLEN-1:0]     r_d;
  logic [XLEN-1:0]     amo_new;
  logic [XLEN-1:0]     old_ext;

  assign req_misaligned = req_is_word ? (|req_addr[1:0]) : (|req_addr[2:0]);
  assign req_fault      = req_misaligned || (req_op > OP_MAXU);

  // AMO combine function on the returning read data; word ops use bits [31:0]
  always_comb begin
    a_w = mem_resp_rdata[31:0];
    b_w = wdata_q[31:0];
    r_w = b_w;
    r_d = wdata_q;
    case (op_q)
      OP_ADD: begin
        r_w = a_w + b_w;
        r_d = mem_resp_rdata + wdata_q;
      end
      OP_XOR: begin
        r_w = a_w ^ b_w;
        r_d = mem_resp_rdata ^ wdata_q;
      end
      OP_AND: begin
        r_w = a_w & b_w;
        r_d = mem_resp_rdata & wdata_q;
      end
      OP_OR: begin
        r_w = a_w | b_w;
        r_d = mem_resp_rdata | wdata_q;
      end
      OP_MIN: begin
        r_w = ($signed(a_w) < $signed(b_w)) ? a_w : b_w;
        r_d = ($signed(mem_resp_rdata) < $signed(wdata_q)) ? mem_resp_rdata : wdata_q;
      end
      OP_MAX: begin
        r_w = ($signed(a_w) > $signed(b_w)) ? a_w : b_w;
        r_d = ($signed(mem_resp_rdata) > $signed(wdata_q)) ? mem_resp_rdata : wdata_q;
      end
      OP_MINU: begin
        r_w = (a_w < b_w) ? a_w : b_w;
        r_d = (mem_resp_rdata < wdata_q) ? mem_resp_rdata : wdata_q;
      end
      OP_MAXU: begin
        r_w = (a_w > b_w) ? a_w : b_w;
        r_d = (mem_resp_rdata > wdata_q) ? mem_resp_rdata : wdata_q;
      end
      default: begin
        r_w = b_w;
        r_d = wdata_q;
      end
    endcase
    amo_new = is_word_q ? {{(XLEN-32){1'b0}}, r_w} : r_d;
    old_ext = is_word_q ? {{(XLEN-32){mem_resp_rdata[31]}}, mem_resp_rdata[31:0]}
                        : mem_resp_rdata;
  end

  // Next-state and latch updates for the op sequencer
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    is_word_d = is_word_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    hart_d    = hart_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          is_word_d = req_is_word;
          addr_d    = req_addr;
          wdata_d   = req_is_word ? {{(XLEN-32){1'b0}}, req_wdata[31:0]} : req_wdata;
          hart_d    = req_hart_id;
          rdata_d   = '0;
          fault_d   = 1'b0;
          if (req_fault) begin
            fault_d = 1'b1;
            state_d = S_RESP;
          end else if (req_op == OP_SC) begin
            state_d = S_SC_CHECK;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_SC_CHECK: begin
        if (rs_sc_success) begin
          state_d = S_WR_REQ;
        end else begin
          rdata_d = {{(XLEN-1){1'b0}}, 1'b1};
          state_d = S_RESP;
        end
      end
      S_RD_REQ: begin
        if (mem_req_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = old_ext;
          if (op_q == OP_LR) begin
            state_d = S_RESP;
          end else begin
            wdata_d = amo_new;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (mem_req_ready) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mem_resp_valid) begin
          if (op_q == OP_SC) rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latch registers; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      is_word_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      hart_q    <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      is_word_q <= is_word_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      hart_q    <= hart_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
    end
  end

  assign req_ready        = (state_q == S_IDLE);
  assign resp_valid       = (state_q == S_RESP);
  assign resp_rdata       = (state_q == S_RESP) ? rdata_q : '0;
  assign resp_fault       = (state_q == S_RESP) && fault_q;

  assign mem_req_valid    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign mem_req_we       = (state_q == S_WR_REQ);
  assign mem_req_addr     = addr_q;
  assign mem_req_wdata    = wdata_q;
  assign mem_req_is_word  = is_word_q;

  assign rs_hart_id       = hart_q;
  assign rs_lr_valid      = (state_q == S_RD_WAIT) && (op_q == OP_LR) && mem_resp_valid;
  assign rs_lr_addr       = addr_q;
  assign rs_lr_is_word    = is_word_q;
  assign rs_sc_valid      = (state_q == S_SC_CHECK);
  assign rs_sc_addr       = addr_q;
  assign rs_sc_is_word    = is_word_q;
  assign rs_store_valid   = (state_q == S_WR_WAIT) && mem_resp_valid;
  assign rs_store_addr    = addr_q;
  assign rs_store_hart_id = hart_q;

endmodule

// File: tb/tb_amo_lrsc_unit.sv
// Scoreboard bench for amo_lrsc_unit: directed ops, expected events queued,
// a monitor pops and compares whenever the DUT produces an event.
module tb_amo_lrsc_unit;

  localparam int XLEN = 64;
  localparam int NUM_HARTS = 4;
  localparam int HART_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic              req_is_word;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [HART_W-1:0] req_hart_id;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_fault;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [XLEN-1:0]   mem_req_addr;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_req_is_word;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_rdata;
  logic [HART_W-1:0] rs_hart_id;
  logic              rs_lr_valid;
  logic [XLEN-1:0]   rs_lr_addr;
  logic              rs_lr_is_word;
  logic              rs_sc_valid;
  logic [XLEN-1:0]   rs_sc_addr;
  logic              rs_sc_is_word;
  logic              rs_sc_success;
  logic              rs_store_valid;
  logic [XLEN-1:0]   rs_store_addr;
  logic [HART_W-1:0] rs_store_hart_id;

  always #5 clk = ~clk;

  amo_lrsc_unit #(.XLEN(XLEN), .NUM_HARTS(NUM_HARTS), .HART_W(HART_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_is_word(req_is_word), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_hart_id(req_hart_id),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_is_word(mem_req_is_word),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .rs_hart_id(rs_hart_id), .rs_lr_valid(rs_lr_valid), .rs_lr_addr(rs_lr_addr),
    .rs_lr_is_word(rs_lr_is_word), .rs_sc_valid(rs_sc_valid), .rs_sc_addr(rs_sc_addr),
    .rs_sc_is_word(rs_sc_is_word), .rs_sc_success(rs_sc_success),
    .rs_store_valid(rs_store_valid), .rs_store_addr(rs_store_addr),
    .rs_store_hart_id(rs_store_hart_id)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    int          lat;
  } resp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        is_word;
  } memreq_t;

  typedef struct {
    logic [63:0] addr;
    logic        is_word;
    logic [1:0]  hart;
  } rsev_t;

  resp_t   respq[$];
  memreq_t memq[$];
  rsev_t   lrq[$];
  rsev_t   scq[$];
  rsev_t   stq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_seen = 0;
  int mem_seen = 0;

  logic [63:0] rd_data = 64'h0;
  logic        auto_resp = 1'b1;
  logic        manual_resp = 1'b0;
  int          wr_stall_cfg = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory model: responds one cycle after each handshake, optional write stall
  initial begin
    logic hs_prev;
    int   stall_cnt;
    hs_prev = 1'b0;
    stall_cnt = 0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = auto_resp ? hs_prev : manual_resp;
      mem_resp_rdata = rd_data;
      if (mem_req_valid && mem_req_we && (stall_cnt < wr_stall_cfg)) begin
        mem_req_ready = 1'b0;
        stall_cnt++;
      end else begin
        mem_req_ready = 1'b1;
      end
      hs_prev = mem_req_valid && mem_req_ready && !rst;
      if (hs_prev) stall_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows an event
  initial begin
    logic        stall_seen;
    logic [63:0] snap_addr;
    logic [63:0] snap_wdata;
    logic        snap_we;
    stall_seen = 1'b0;
    snap_addr = '0;
    snap_wdata = '0;
    snap_we = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        if (respq.size() == 0) chk("unexpected_resp", 64'(resp_rdata), 64'h0 - 64'h1);
        else begin
          resp_t e;
          e = respq.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_fault", 64'(resp_fault), 64'(e.fault));
          chk("resp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          $display("resp rdata=%h fault=%0d lat=%0d", resp_rdata, resp_fault, cyc - acc_cyc);
        end
        resp_seen++;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (memq.size() == 0) chk("unexpected_mem_req", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          memreq_t m;
          m = memq.pop_front();
          chk("mem_we", 64'(mem_req_we), 64'(m.we));
          chk("mem_addr", mem_req_addr, m.addr);
          chk("mem_is_word", 64'(mem_req_is_word), 64'(m.is_word));
          if (m.we) begin
            if (m.is_word) chk("mem_wdata_w", 64'(mem_req_wdata[31:0]), 64'(m.wdata[31:0]));
            else           chk("mem_wdata_d", mem_req_wdata, m.wdata);
          end
          $display("mem we=%0d addr=%h wdata=%h", mem_req_we, mem_req_addr, mem_req_wdata);
        end
        mem_seen++;
      end
      if (stall_seen && mem_req_valid) begin
        chk("stall_addr_stable", mem_req_addr, snap_addr);
        chk("stall_wdata_stable", mem_req_wdata, snap_wdata);
        chk("stall_we_stable", 64'(mem_req_we), 64'(snap_we));
      end
      stall_seen = mem_req_valid && !mem_req_ready;
      snap_addr = mem_req_addr;
      snap_wdata = mem_req_wdata;
      snap_we = mem_req_we;
      if (rs_lr_valid) begin
        if (lrq.size() == 0) chk("unexpected_lr", rs_lr_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          rsev_t r;
          r = lrq.pop_front();
          chk("lr_addr", rs_lr_addr, r.addr);
          chk("lr_is_word", 64'(rs_lr_is_word), 64'(r.is_word));
          chk("lr_hart", 64'(rs_hart_id), 64'(r.hart));
        end
      end
      if (rs_sc_valid) begin
        if (scq.size() == 0) chk("unexpected_sc", rs_sc_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          rsev_t r;
          r = scq.pop_front();
          chk("sc_addr", rs_sc_addr, r.addr);
          chk("sc_is_word", 64'(rs_sc_is_word), 64'(r.is_word));
          chk("sc_hart", 64'(rs_hart_id), 64'(r.hart));
        end
      end
      if (rs_store_valid) begin
        if (stq.size() == 0) chk("unexpected_store", rs_store_addr, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          rsev_t r;
          r = stq.pop_front();
          chk("store_addr", rs_store_addr, r.addr);
          chk("store_hart", 64'(rs_store_hart_id), 64'(r.hart));
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] d, input logic [1:0] h);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_is_word = w;
    req_addr = a;
    req_wdata = d;
    req_hart_id = h;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n0);
    int n;
    n = 0;
    while (resp_seen <= n0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (resp_seen <= n0) chk("resp_timeout", 64'(resp_seen), 64'(n0 + 1));
  endtask

  task automatic run_op(input logic [3:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] d, input logic [1:0] h);
    int n0;
    n0 = resp_seen;
    $display("op=%0d word=%0d addr=%h wdata=%h hart=%0d", op, w, a, d, h);
    issue(op, w, a, d, h);
    wait_resp(n0);
  endtask

  task automatic amo(input logic [3:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] old, input logic [63:0] d,
                     input logic [63:0] newv, input logic [63:0] rdv, input logic [1:0] h);
    rd_data = old;
    memq.push_back('{1'b0, a, 64'h0, w});
    memq.push_back('{1'b1, a, newv, w});
    stq.push_back('{a, w, h});
    respq.push_back('{rdv, 1'b0, 5});
    run_op(op, w, a, d, h);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = '0;
    req_is_word = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_hart_id = '0;
    rs_sc_success = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_mem_req_addr", mem_req_addr, 64'h0);
    chk("rst_rs_pulses", 64'({rs_lr_valid, rs_sc_valid, rs_store_valid}), 64'h0);
    rst = 1'b0;

    // LR.D and LR.W (sign extension of the loaded word)
    rd_data = 64'hDEAD_BEEF_0000_0001;
    memq.push_back('{1'b0, 64'h1000, 64'h0, 1'b0});
    lrq.push_back('{64'h1000, 1'b0, 2'd1});
    respq.push_back('{64'hDEAD_BEEF_0000_0001, 1'b0, 3});
    run_op(4'd0, 1'b0, 64'h1000, 64'h0, 2'd1);

    rd_data = 64'h1111_1111_8000_0002;
    memq.push_back('{1'b0, 64'h1008, 64'h0, 1'b1});
    lrq.push_back('{64'h1008, 1'b1, 2'd1});
    respq.push_back('{64'hFFFF_FFFF_8000_0002, 1'b0, 3});
    run_op(4'd0, 1'b1, 64'h1008, 64'h0, 2'd1);

    // SC.W success, then failure, then SC.D success
    rs_sc_success = 1'b1;
    scq.push_back('{64'h2000, 1'b1, 2'd2});
    memq.push_back('{1'b1, 64'h2000, 64'h1234, 1'b1});
    stq.push_back('{64'h2000, 1'b1, 2'd2});
    respq.push_back('{64'h0, 1'b0, 4});
    run_op(4'd1, 1'b1, 64'h2000, 64'hAAAA_AAAA_0000_1234, 2'd2);

    rs_sc_success = 1'b0;
    scq.push_back('{64'h2000, 1'b1, 2'd2});
    respq.push_back('{64'h1, 1'b0, 2});
    run_op(4'd1, 1'b1, 64'h2000, 64'h1234, 2'd2);

    rs_sc_success = 1'b1;
    scq.push_back('{64'h2008, 1'b0, 2'd0});
    memq.push_back('{1'b1, 64'h2008, 64'h0123_4567_89AB_CDEF, 1'b0});
    stq.push_back('{64'h2008, 1'b0, 2'd0});
    respq.push_back('{64'h0, 1'b0, 4});
    run_op(4'd1, 1'b0, 64'h2008, 64'h0123_4567_89AB_CDEF, 2'd0);
    rs_sc_success = 1'b0;

    // AMOs: op, word, addr, old, rs2, new, rd, hart
    amo(4'd3,  1'b1, 64'h3000, 64'hABCD_0000_7FFF_FFFF, 64'h1,
        64'h8000_0000, 64'h0000_0000_7FFF_FFFF, 2'd0);
    amo(4'd7,  1'b1, 64'h3004, 64'h0000_0000_FFFF_FFFF, 64'h5,
        64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    amo(4'd9,  1'b1, 64'h3004, 64'h0000_0000_FFFF_FFFF, 64'h5,
        64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
    amo(4'd8,  1'b0, 64'h3008, 64'h8000_0000_0000_0000, 64'h1,
        64'h1, 64'h8000_0000_0000_0000, 2'd1);
    amo(4'd3,  1'b0, 64'h3008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
        64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1);
    amo(4'd4,  1'b0, 64'h3010, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
        64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 2'd2);
    amo(4'd5,  1'b1, 64'h3010, 64'h0000_0000_F0F0_1234, 64'hFF00_FF00,
        64'hF000_1200, 64'hFFFF_FFFF_F0F0_1234, 2'd2);
    amo(4'd10, 1'b1, 64'h3014, 64'h0000_0000_8000_0000, 64'h7FFF_FFFF,
        64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 2'd0);
    amo(4'd2,  1'b1, 64'h3018, 64'h0000_0000_0000_0011, 64'h22,
        64'h22, 64'h11, 2'd0);

    // Faults: misaligned .D, illegal op, misaligned .W, misaligned SC
    respq.push_back('{64'h0, 1'b1, 1});
    run_op(4'd2, 1'b0, 64'h4004, 64'h55, 2'd1);
    respq.push_back('{64'h0, 1'b1, 1});
    run_op(4'd12, 1'b1, 64'h5000, 64'h55, 2'd1);
    respq.push_back('{64'h0, 1'b1, 1});
    run_op(4'd3, 1'b1, 64'h4002, 64'h1, 2'd1);
    rs_sc_success = 1'b1;
    respq.push_back('{64'h0, 1'b1, 1});
    run_op(4'd1, 1'b1, 64'h4001, 64'h1, 2'd1);
    rs_sc_success = 1'b0;

    // AMOOR.D with 3 cycles of write backpressure
    wr_stall_cfg = 3;
    rd_data = 64'hF0;
    memq.push_back('{1'b0, 64'h6000, 64'h0, 1'b0});
    memq.push_back('{1'b1, 64'h6000, 64'hFF0, 1'b0});
    stq.push_back('{64'h6000, 1'b0, 2'd2});
    respq.push_back('{64'hF0, 1'b0, 8});
    run_op(4'd6, 1'b0, 64'h6000, 64'hF00, 2'd2);
    wr_stall_cfg = 0;

    // Reset while an AMO waits for read data; the late response is ignored
    auto_resp = 1'b0;
    rd_data = 64'h77;
    memq.push_back('{1'b0, 64'h7000, 64'h0, 1'b0});
    n = mem_seen;
    $display("op=3 word=0 addr=0000000000007000 reset during read wait");
    issue(4'd3, 1'b0, 64'h7000, 64'h1, 2'd3);
    begin
      int k;
      k = 0;
      while (mem_seen <= n && k < 40) begin
        @(negedge clk);
        k++;
      end
    end
    chk("abort_read_issued", 64'(mem_seen), 64'(n + 1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    manual_resp = 1'b1;
    @(posedge clk);
    #2;
    manual_resp = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_req_ready", 64'(req_ready), 64'h1);
    chk("abort_outputs_idle",
        64'({mem_req_valid, mem_req_we, resp_valid, rs_lr_valid, rs_sc_valid, rs_store_valid}),
        64'h0);
    chk("abort_mem_req_addr", mem_req_addr, 64'h0);
    auto_resp = 1'b1;

    // Recovery after abort
    rd_data = 64'h42;
    memq.push_back('{1'b0, 64'h7008, 64'h0, 1'b0});
    lrq.push_back('{64'h7008, 1'b0, 2'd0});
    respq.push_back('{64'h42, 1'b0, 3});
    run_op(4'd0, 1'b0, 64'h7008, 64'h0, 2'd0);

    repeat (3) @(negedge clk);
    chk("left_resp", 64'(respq.size()), 64'h0);
    chk("left_mem", 64'(memq.size()), 64'h0);
    chk("left_lr", 64'(lrq.size()), 64'h0);
    chk("left_sc", 64'(scq.size()), 64'h0);
    chk("left_store", 64'(stq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
